// File: rtl/kmeans_pkg.sv
// Shared widths, FSM state type and coordinate-slice helpers for the
// centroid-update datapath.
package kmeans_pkg;

    localparam int CENT_NUM   = 8;
    localparam int COORD_NUM  = 7;
    localparam int ACC_CORD_W = 22;
    localparam int CORD_W     = 13;
    localparam int COUNT_W    = 10;
    localparam int ACCUM_W    = COORD_NUM * ACC_CORD_W;
    localparam int DATA_W     = COORD_NUM * CORD_W;
    localparam int IDX_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        EMIT,
        DONE
    } nm_state_t;

    function automatic logic [ACC_CORD_W-1:0] acc_coord(
        input logic [ACCUM_W-1:0] v,
        input logic [IDX_W-1:0]   k
    );
        return v[k*ACC_CORD_W +: ACC_CORD_W];
    endfunction

    function automatic logic [CORD_W-1:0] cent_coord(
        input logic [DATA_W-1:0] v,
        input logic [IDX_W-1:0]  k
    );
        return v[k*CORD_W +: CORD_W];
    endfunction

    function automatic logic [DATA_W-1:0] set_coord(
        input logic [DATA_W-1:0] v,
        input logic [IDX_W-1:0]  k,
        input logic [CORD_W-1:0] c
    );
        logic [DATA_W-1:0] r;
        r = v;
        r[k*CORD_W +: CORD_W] = c;
        return r;
    endfunction

endpackage

// File: rtl/new_means_calc_block_if.sv
// Controller / accumulator-bank / centroid-stream signals of the new-means block.
interface new_means_calc_block_if;
    import kmeans_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     acc_sel;
    logic [ACCUM_W-1:0]   accum_in;
    logic [COUNT_W-1:0]   count_in;
    logic [DATA_W-1:0]    old_centroid_in;
    logic [DATA_W-1:0]    new_centroid_out;
    logic [IDX_W-1:0]     cent_num;
    logic                 cent_valid;

    modport master (
        output start, accum_in, count_in, old_centroid_in,
        input  busy, done, acc_sel, new_centroid_out, cent_num, cent_valid
    );

    modport slave (
        input  start, accum_in, count_in, old_centroid_in,
        output busy, done, acc_sel, new_centroid_out, cent_num, cent_valid
    );

endinterface

// File: rtl/serial_restoring_divider.sv
// Restoring divider, one quotient bit per step (MSB first), with the
// quotient saturated to the output width on the final step.
module serial_restoring_divider #(
    parameter int dividend_w = 22,
    parameter int divisor_w  = 10,
    parameter int out_w      = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [dividend_w-1:0] dividend,
    input  logic [divisor_w-1:0]  divisor,
    output logic                  last,
    output logic [out_w-1:0]      quot_sat
);
    localparam int cnt_w = $clog2(dividend_w);
    localparam logic [dividend_w-1:0] sat_max = dividend_w'((1 << out_w) - 1);

    logic [dividend_w-1:0] dvd_q, quo_q, quo_nxt;
    logic [divisor_w-1:0]  dvs_q;
    logic [divisor_w:0]    rem_q, rem_shift, rem_nxt;
    logic [cnt_w-1:0]      bit_cnt_q;
    logic                  ge;
    logic                  unused_rem_msb;

    // rem < divisor always holds, so the MSB of the register never carries into the shift
    assign unused_rem_msb = rem_q[divisor_w];
    assign rem_shift = {rem_q[divisor_w-1:0], dvd_q[bit_cnt_q]};
    assign ge        = rem_shift >= {1'b0, dvs_q};
    assign rem_nxt   = ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    assign quo_nxt   = {quo_q[dividend_w-2:0], ge};
    assign last      = (bit_cnt_q == '0);
    assign quot_sat  = (quo_nxt > sat_max) ? sat_max[out_w-1:0] : quo_nxt[out_w-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            dvd_q     <= dividend;
            dvs_q     <= divisor;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= cnt_w'(dividend_w - 1);
        end else if (step) begin
            rem_q     <= rem_nxt;
            quo_q     <= quo_nxt;
            bit_cnt_q <= bit_cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/new_means_calc_block.sv
// Walks every centroid, divides each accumulated coordinate sum by the member
// count and streams the resulting centroids to the convergence checker.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch coordinate sum and count into the divider (or copy old coord if empty)
// DIV   | one restoring-division step per cycle, result written on the last step
// EMIT  | centroid strobe on cent_valid
// DONE  | one-cycle done pulse
module new_means_calc_block
    import kmeans_pkg::*;
#(
    parameter int centroid_num     = CENT_NUM,
    parameter int coord_num        = COORD_NUM,
    parameter int accum_cord_width = ACC_CORD_W,
    parameter int cordinate_width  = CORD_W,
    parameter int count_width      = COUNT_W,
    parameter int accum_width      = ACCUM_W,
    parameter int dataWidth        = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    new_means_calc_block_if.slave bus
);
    nm_state_t state_q, state_nxt;

    logic [IDX_W-1:0]            cent_idx_q, coord_idx_q, cent_num_q;
    logic [dataWidth-1:0]        result_q, result_nxt, out_q;
    logic [accum_width-1:0]      accum_v;
    logic [accum_cord_width-1:0] dividend;
    logic [cordinate_width-1:0]  quot_sat, wr_val;
    logic                        div_load, div_step, div_last;
    logic                        wr_en, out_load, advance;
    logic                        cent_start, cent_inc, coord_inc;

    assign accum_v    = bus.accum_in;
    assign dividend   = acc_coord(accum_v, coord_idx_q);
    assign result_nxt = set_coord(result_q, coord_idx_q, wr_val);

    serial_restoring_divider #(
        .dividend_w (accum_cord_width),
        .divisor_w  (count_width),
        .out_w      (cordinate_width)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .step     (div_step),
        .dividend (dividend),
        .divisor  (bus.count_in),
        .last     (div_last),
        .quot_sat (quot_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        div_load   = 1'b0;
        div_step   = 1'b0;
        wr_en      = 1'b0;
        wr_val     = '0;
        advance    = 1'b0;
        out_load   = 1'b0;
        cent_start = 1'b0;
        cent_inc   = 1'b0;
        coord_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cent_start = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                div_load = 1'b1;
                if (bus.count_in == '0) begin
                    // empty cluster keeps its previous position
                    wr_en   = 1'b1;
                    wr_val  = cent_coord(bus.old_centroid_in, coord_idx_q);
                    advance = 1'b1;
                end else begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    wr_en   = 1'b1;
                    wr_val  = quot_sat;
                    advance = 1'b1;
                end
            end
            EMIT: begin
                if (cent_idx_q == IDX_W'(centroid_num - 1)) begin
                    state_nxt = DONE;
                end else begin
                    cent_inc  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (advance) begin
            if (coord_idx_q == IDX_W'(coord_num - 1)) begin
                out_load  = 1'b1;
                state_nxt = EMIT;
            end else begin
                coord_inc = 1'b1;
                state_nxt = LOAD;
            end
        end
    end

    // The output register captures the completed vector as the last slot is
    // written, so it is already valid during the EMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cent_idx_q  <= '0;
            coord_idx_q <= '0;
            result_q    <= '0;
            out_q       <= '0;
            cent_num_q  <= '0;
        end else begin
            if (cent_start) begin
                cent_idx_q  <= '0;
                coord_idx_q <= '0;
            end else if (cent_inc) begin
                cent_idx_q  <= cent_idx_q + 1'b1;
                coord_idx_q <= '0;
            end else if (coord_inc) begin
                coord_idx_q <= coord_idx_q + 1'b1;
            end
            if (wr_en) begin
                result_q <= result_nxt;
            end
            if (out_load) begin
                out_q      <= result_nxt;
                cent_num_q <= cent_idx_q;
            end
        end
    end

    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = (state_q == DONE);
    assign bus.cent_valid       = (state_q == EMIT);
    assign bus.acc_sel          = cent_idx_q;
    assign bus.new_centroid_out = out_q;
    assign bus.cent_num         = cent_num_q;

endmodule

// File: tb/tb_new_means_calc_block.sv
// Directed + randomized bench for new_means_calc_block with an arithmetic
// reference model of the centroid update and its cycle timing.
module tb_new_means_calc_block;
    import kmeans_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    new_means_calc_block_if bus();

    new_means_calc_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned acc_m [8][7];
    int unsigned old_m [8][7];
    int unsigned cnt_m [8];
    int checks   = 0;
    int failures = 0;

    // accumulator bank / old-centroid store, addressed by acc_sel
    always_comb begin
        bus.accum_in        = '0;
        bus.old_centroid_in = '0;
        for (int k = 0; k < 7; k++) begin
            bus.accum_in[k*22 +: 22]        = acc_m[bus.acc_sel][k][21:0];
            bus.old_centroid_in[k*13 +: 13] = old_m[bus.acc_sel][k][12:0];
        end
        bus.count_in = cnt_m[bus.acc_sel][9:0];
    end

    task automatic chk(input string tag, input logic [90:0] obs, input logic [90:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [90:0] exp_vec(input int c);
        logic [90:0] v;
        longint unsigned q;
        v = '0;
        for (int k = 0; k < 7; k++) begin
            if (cnt_m[c] == 0) begin
                q = old_m[c][k];
            end else begin
                q = acc_m[c][k] / cnt_m[c];
                if (q > 8191) q = 8191;
            end
            v[k*13 +: 13] = q[12:0];
        end
        return v;
    endfunction

    task automatic fill_random(input bit allow_zero);
        for (int c = 0; c < 8; c++) begin
            if (allow_zero && $urandom_range(0, 3) == 0) cnt_m[c] = 0;
            else cnt_m[c] = $urandom_range(1, 1023);
            for (int k = 0; k < 7; k++) begin
                acc_m[c][k] = $urandom_range(0, 4194303);
                old_m[c][k] = $urandom_range(0, 8191);
            end
        end
    endtask

    // Runs one pass from a start pulse. abort_at>0 pulls reset in that cycle.
    task automatic run_pass(input int abort_at, input int s1, input int s2);
        int exp_t[8];
        int t, fin, nemit, ndone, last_v, strobes;
        t = 0;
        for (int c = 0; c < 8; c++) begin
            t += (cnt_m[c] == 0) ? 8 : 162;
            exp_t[c] = t;
        end
        fin    = exp_t[7] + 2;
        nemit  = 0;
        ndone  = 0;
        last_v = -100;

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1'b1);

        for (int cyc = 1; cyc <= fin; cyc++) begin
            if (cyc > 1) @(negedge clk);
            bus.start = (cyc == s1 || cyc == s2);
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n     = 1'b0;
                bus.start = 1'b0;
                #1;
                chk("abort_busy", bus.busy, 1'b0);
                chk("abort_done", bus.done, 1'b0);
                chk("abort_valid", bus.cent_valid, 1'b0);
                chk("abort_data", bus.new_centroid_out, '0);
                chk("abort_num", bus.cent_num, 3'd0);
                chk("abort_sel", bus.acc_sel, 3'd0);
                repeat (2) @(negedge clk);
                rst_n   = 1'b1;
                strobes = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (bus.cent_valid || bus.done) strobes++;
                end
                chk("abort_no_strobe", strobes, 0);
                chk("abort_idle", bus.busy, 1'b0);
                return;
            end
            if (bus.cent_valid) begin
                if (nemit < 8) begin
                    chk("cent_num", bus.cent_num, nemit);
                    chk("cent_data", bus.new_centroid_out, exp_vec(nemit));
                    chk("emit_cycle", cyc, exp_t[nemit]);
                end
                chk("valid_spacing", (cyc - last_v) >= 8, 1'b1);
                last_v = cyc;
                nemit++;
            end
            if (bus.done) begin
                chk("done_cycle", cyc, exp_t[7] + 1);
                ndone++;
            end
            if (cyc == fin - 1) chk("busy_in_done", bus.busy, 1'b1);
            if (cyc == fin) chk("busy_fall", bus.busy, 1'b0);
        end
        chk("emit_count", nemit, 8);
        chk("done_count", ndone, 1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cnt_m[c] = 1;
            for (int k = 0; k < 7; k++) begin
                acc_m[c][k] = k;
                old_m[c][k] = $urandom_range(0, 8191);
            end
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_valid", bus.cent_valid, 1'b0);
        chk("rst_data", bus.new_centroid_out, '0);
        chk("rst_num", bus.cent_num, 3'd0);
        chk("rst_sel", bus.acc_sel, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // all counts 1, sums 0..6
        run_pass(0, 0, 0);

        // directed quotients, saturation, empty cluster, ignored starts
        fill_random(1'b0);
        cnt_m[0] = 3;    acc_m[0][0] = 10;      acc_m[0][1] = 11;
        cnt_m[1] = 1023; acc_m[1][0] = 4194303;
        cnt_m[2] = 0;
        for (int k = 0; k < 7; k++) old_m[2][k] = 13'h1555;
        cnt_m[3] = 1;    acc_m[3][0] = 4194303;
        run_pass(0, 50, 500);

        // random with empty clusters
        fill_random(1'b1);
        run_pass(0, 0, 0);
        fill_random(1'b1);
        run_pass(0, 77, 0);

        // reset during DIV of centroid 4, then a fresh pass
        fill_random(1'b0);
        run_pass(700, 0, 0);
        fill_random(1'b0);
        run_pass(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
